// File: rtl/frodo_mac_pkg.sv
// rtl/frodo_mac_pkg.sv - shared constants and q_log mask helper for the FRODO multiply-add pipe
// Contents: default LANES/AW/BW, q_log field width, q_mask() building the modulus mask.
package frodo_mac_pkg;

    localparam int LANES_DEF = 4;
    localparam int AW_DEF    = 16;
    localparam int BW_DEF    = 5;
    localparam int QW        = 5;

    // Low-order ones mask for mod 2^q; q of 0 or wider than aw selects the full aw bits.
    function automatic logic [31:0] q_mask(input logic [QW-1:0] q, input int aw);
        int          eff;
        logic [63:0] m;
        eff = ((q == '0) || (int'(q) > aw)) ? aw : int'(q);
        m   = (64'd1 << eff) - 64'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/frodo_mac_pipe_if.sv
// rtl/frodo_mac_pipe_if.sv - operand/result handshake bundle for frodo_mac_pipe
// Signals: in_valid/in_ready/in_a/in_b/in_c/q_log (beat in), out_valid/out_ready/result (beat out),
// acc_sel/acc_clr only when FRODO_MAC_ACC_EN is defined.
// Modports: master drives beats and out_ready; slave is the pipeline's view.
interface frodo_mac_pipe_if
    import frodo_mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int AW    = AW_DEF,
    parameter int BW    = BW_DEF
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*AW-1:0]   in_a;
    logic [LANES*BW-1:0]   in_b;
    logic [LANES*AW-1:0]   in_c;
    logic [QW-1:0]         q_log;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*AW-1:0]   result;
`ifdef FRODO_MAC_ACC_EN
    logic                  acc_sel;
    logic                  acc_clr;
`endif

    modport master (
`ifdef FRODO_MAC_ACC_EN
        output acc_sel,
        output acc_clr,
`endif
        output in_valid,
        output in_a,
        output in_b,
        output in_c,
        output q_log,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

    modport slave (
`ifdef FRODO_MAC_ACC_EN
        input  acc_sel,
        input  acc_clr,
`endif
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_c,
        input  q_log,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );

endinterface

// File: rtl/frodo_mac_lane.sv
// rtl/frodo_mac_lane.sv - one lane datapath: S1 product/addend capture, S2 add and q_log mask
// Ports: clk, rstn (async active-low), s1_en_i/s2_en_i stage loads, a_i/b_i/c_i operands,
// mask_i modulus mask for the beat entering S2, result_o; with FRODO_MAC_ACC_EN also
// acc_sel_i/acc_clr_i (the S1 beat's flags) and out_fire_i (result leaving this cycle).
module frodo_mac_lane
    import frodo_mac_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s1_en_i,
    input  logic          s2_en_i,
    input  logic [AW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    input  logic [AW-1:0] c_i,
    input  logic [AW-1:0] mask_i,
`ifdef FRODO_MAC_ACC_EN
    input  logic          acc_sel_i,
    input  logic          acc_clr_i,
    input  logic          out_fire_i,
`endif
    output logic [AW-1:0] result_o
);

    logic [AW-1:0] b_ext;
    logic [AW-1:0] prod_d, prod_q;
    logic [AW-1:0] c_q;
    logic [AW-1:0] addend;
    logic [AW-1:0] res_d, res_q;

    // Multiplying in AW bits gives the product mod 2^AW directly.
    assign b_ext  = {{(AW-BW){b_i[BW-1]}}, b_i};
    assign prod_d = a_i * b_ext;

`ifdef FRODO_MAC_ACC_EN
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_eff;

    // When the older result leaves in the same cycle this beat enters S2, the
    // accumulator has not loaded it yet, so forward it.
    assign acc_eff = out_fire_i ? res_q : acc_q;
    assign addend  = acc_clr_i ? '0 : (acc_sel_i ? acc_eff : c_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else if (out_fire_i) begin
            acc_q <= res_q;
        end
    end
`else
    assign addend = c_q;
`endif

    assign res_d = (prod_q + addend) & mask_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q <= '0;
            c_q    <= '0;
            res_q  <= '0;
        end else begin
            if (s1_en_i) begin
                prod_q <= prod_d;
                c_q    <= c_i;
            end
            if (s2_en_i) begin
                res_q <= res_d;
            end
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/frodo_mac_pipe.sv
// rtl/frodo_mac_pipe.sv - two-stage LANES-wide (a*sext(b)+c) mod 2^q_log pipeline with valid/ready
// Ports: clk, rstn (async active-low), bus (frodo_mac_pipe_if.slave).
// Optional: FRODO_MAC_ACC_EN adds per-lane accumulation selected by acc_sel/acc_clr.
module frodo_mac_pipe
    import frodo_mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int AW    = AW_DEF,
    parameter int BW    = BW_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    frodo_mac_pipe_if.slave     bus
);

    logic              ready_en_q;
    logic              s1_valid_d, s1_valid_q;
    logic              s2_valid_d, s2_valid_q;
    logic [QW-1:0]     q_q;
    logic              s2_advance;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic              s2_en;
    logic [AW-1:0]     mask;
    logic [LANES*AW-1:0] result_w;

    assign s2_advance = !s2_valid_q || bus.out_ready;
    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready   = ready_en_q && (!s1_valid_q || s2_advance);
    assign in_fire    = bus.in_valid && in_ready;
    assign out_fire   = s2_valid_q && bus.out_ready;
    assign s2_en      = s2_advance && s1_valid_q;
    assign mask       = AW'(q_mask(q_q, AW));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
        end
    end

`ifdef FRODO_MAC_ACC_EN
    logic acc_sel_q;
    logic acc_clr_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            q_q        <= '0;
`ifdef FRODO_MAC_ACC_EN
            acc_sel_q  <= 1'b0;
            acc_clr_q  <= 1'b0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                q_q <= bus.q_log;
`ifdef FRODO_MAC_ACC_EN
                acc_sel_q <= bus.acc_sel;
                acc_clr_q <= bus.acc_clr;
`endif
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        frodo_mac_lane #(
            .AW(AW),
            .BW(BW)
        ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .s1_en_i   (in_fire),
            .s2_en_i   (s2_en),
            .a_i       (bus.in_a[i*AW +: AW]),
            .b_i       (bus.in_b[i*BW +: BW]),
            .c_i       (bus.in_c[i*AW +: AW]),
            .mask_i    (mask),
`ifdef FRODO_MAC_ACC_EN
            .acc_sel_i (acc_sel_q),
            .acc_clr_i (acc_clr_q),
            .out_fire_i(out_fire),
`endif
            .result_o  (result_w[i*AW +: AW])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_w;

endmodule

// File: tb/tb_frodo_mac_pipe.sv
// tb/tb_frodo_mac_pipe.sv - self-checking bench for frodo_mac_pipe (LANES=4, AW=16, BW=5)
module tb_frodo_mac_pipe;
    import frodo_mac_pkg::*;

    localparam int LANES = 4;
    localparam int AW    = 16;
    localparam int BW    = 5;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    frodo_mac_pipe_if #(.LANES(LANES), .AW(AW), .BW(BW)) bus ();

    frodo_mac_pipe #(.LANES(LANES), .AW(AW), .BW(BW)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a_v, input logic [19:0] b_v,
                                          input logic [63:0] c_v, input logic [4:0] q);
        logic [63:0] r;
        int          eff;
        r   = '0;
        eff = ((q == 5'd0) || (q > 5'd16)) ? 16 : int'(q);
        for (int i = 0; i < LANES; i++) begin
            logic signed [4:0] bs;
            longint av, bv, cv, s, m;
            bs = b_v[i*5 +: 5];
            av = longint'(a_v[i*16 +: 16]);
            bv = longint'(bs);
            cv = longint'(c_v[i*16 +: 16]);
            s  = av * bv + cv;
            m  = (longint'(1) << eff) - 1;
            r[i*16 +: 16] = 16'(s & m);
        end
        return r;
    endfunction

    task automatic set_beat(input logic [63:0] a, input logic [19:0] b, input logic [63:0] c,
                            input logic [4:0] q);
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_c  = c;
        bus.q_log = q;
    endtask

    // One isolated beat with out_ready high: accepted at the next edge, visible two edges later.
    task automatic send_one(input string tag, input logic [63:0] a, input logic [19:0] b,
                            input logic [63:0] c, input logic [4:0] q, input logic [63:0] exp);
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_beat(a, b, c, q);
        bus.in_valid = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        #1 check({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_result"}, bus.result, exp);
    endtask

    task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len,
                              input bit rnd_ready);
        logic [63:0] exp_q[$];
        logic [63:0] ea;
        logic [19:0] eb;
        logic [63:0] ec;
        logic [4:0]  eq;
        int  sent = 0;
        int  got = 0;
        int  cyc = 0;
        int  limit;
        bit  fired = 1'b1;
        bit  saw_block = 1'b0;
        limit = n * 10 + 100;
        bus.in_valid = 1'b0;
        while ((sent < n || exp_q.size() > 0) && cyc < limit) begin
            @(negedge clk);
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            else           bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (fired) begin
                if (sent < n) begin
                    ea = {$urandom, $urandom};
                    eb = 20'($urandom);
                    ec = {$urandom, $urandom};
                    eq = 5'($urandom);
                    set_beat(ea, eb, ec, eq);
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            #1;
            fired = 1'b0;
            if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check({tag, "_extra_result"}, bus.result, 64'hx);
                else                   check({tag, "_result"}, bus.result, exp_q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(ea, eb, ec, eq));
                sent++;
                fired = 1'b1;
            end
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_timeout"}, 64'(cyc >= limit), 64'd0);
        check({tag, "_count"}, 64'(got), 64'(n));
        if (!rnd_ready) check({tag, "_in_ready_drop"}, 64'(saw_block), 64'd1);
    endtask

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_beat('0, '0, '0, 5'd16);
`ifdef FRODO_MAC_ACC_EN
        bus.acc_sel   = 1'b0;
        bus.acc_clr   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("rel_in_ready_pre_edge", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        #1 check("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Lane 0 only: 0x1234*3+1.
        send_one("basic", 64'h1234, 20'd3, 64'h1, 5'd16, 64'h369D);
        // 0x8000 * -16 wraps to 0 in 16 bits, leaving the addend.
        send_one("wrap_q15", 64'h8000, 20'h10, 64'h5, 5'd15, 64'h5);
        send_one("wrap_q16", 64'h8000, 20'h10, 64'h5, 5'd16, 64'h5);
        // Four lanes: 3*-1, 0xFFFF*15+0x10, 0x100*-16+0x1000, 7*2+0xFFF0.
        send_one("lanes_q16", {16'h0007, 16'h0100, 16'hFFFF, 16'h0003},
                 {5'h02, 5'h10, 5'h0F, 5'h1F}, {16'hFFF0, 16'h1000, 16'h0010, 16'h0000},
                 5'd16, {16'hFFFE, 16'h0000, 16'h0001, 16'hFFFD});
        send_one("lanes_q8", {16'h0007, 16'h0100, 16'hFFFF, 16'h0003},
                 {5'h02, 5'h10, 5'h0F, 5'h1F}, {16'hFFF0, 16'h1000, 16'h0010, 16'h0000},
                 5'd8, {16'h00FE, 16'h0000, 16'h0001, 16'h00FD});
        send_one("lanes_q1", {16'h0007, 16'h0100, 16'hFFFF, 16'h0003},
                 {5'h02, 5'h10, 5'h0F, 5'h1F}, {16'hFFF0, 16'h1000, 16'h0010, 16'h0000},
                 5'd1, {16'h0000, 16'h0000, 16'h0001, 16'h0001});
        send_one("lanes_q0", {16'h0007, 16'h0100, 16'hFFFF, 16'h0003},
                 {5'h02, 5'h10, 5'h0F, 5'h1F}, {16'hFFF0, 16'h1000, 16'h0010, 16'h0000},
                 5'd0, {16'hFFFE, 16'h0000, 16'h0001, 16'hFFFD});
        send_one("lanes_q20", {16'h0007, 16'h0100, 16'hFFFF, 16'h0003},
                 {5'h02, 5'h10, 5'h0F, 5'h1F}, {16'hFFF0, 16'h1000, 16'h0010, 16'h0000},
                 5'd20, {16'hFFFE, 16'h0000, 16'h0001, 16'hFFFD});

        run_stream("stall", 10, 4, 3, 1'b0);

        // Two beats in flight, then reset.
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_beat(64'h11, 20'd1, 64'h0, 5'd16);
        bus.in_valid = 1'b1;
        @(negedge clk);
        set_beat(64'h22, 20'd1, 64'h0, 5'd16);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1 check("flight_valid", 64'(bus.out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("flight_rst_valid", 64'(bus.out_valid), 64'd0);
        check("flight_rst_result", bus.result, 64'd0);
        check("flight_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        begin
            int stale = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1 if (bus.out_valid) stale++;
            end
            check("flight_stale", 64'(stale), 64'd0);
        end

`ifdef FRODO_MAC_ACC_EN
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_beat(64'h2, 20'd3, 64'h55, 5'd16);
        bus.acc_clr  = 1'b1;
        bus.acc_sel  = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        set_beat(64'h4, 20'h1F, 64'h77, 5'd16);
        bus.acc_clr = 1'b0;
        bus.acc_sel = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.acc_sel  = 1'b0;
        #1 check("acc_r1", bus.result, 64'h6);
        @(negedge clk);
        #1 check("acc_r2", bus.result, 64'h2);
`endif

        run_stream("random", 10000, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frodo_mac_pipe.md
FRODO_MAC_PIPE -- requirements
Module: frodo_mac_pipe

Interface
REQ-001 Parameter LANES, default 4, number of parallel multiply-add lanes.
REQ-002 Parameter AW, default 16, unsigned multiplier and addend width per lane.
REQ-003 Parameter BW, default 5, signed (two's complement) sample width per lane.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  pipeline accepts beat this cycle.
REQ-008 in_a  input  LANES*AW  lane i multiplier at bits [i*AW +: AW].
REQ-009 in_b  input  LANES*BW  lane i signed sample at bits [i*BW +: BW].
REQ-010 in_c  input  LANES*AW  lane i addend.
REQ-011 q_log  input  5  modulus exponent; result reduced mod 2^q_log; legal values 1..AW.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 result  output  LANES*AW  lane i equals (a*b + c) mod 2^q_log, zero-extended to AW.

Function
REQ-015 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-016 Two-stage pipeline: S1 registers per-lane product a*b truncated to AW bits, plus c and q_log; S2 registers sum masked to q_log bits.
REQ-017 Latency from accepted beat to out_valid: exactly 2 cycles with out_ready held high.
REQ-018 Throughput: one beat per cycle with out_ready high.
REQ-019 A stage advances when its downstream is empty or being drained: in_ready = !s1_valid || s2_advance; s2_advance = !out_valid || out_ready.
REQ-020 When out_valid is high and out_ready is low, result and out_valid hold stable; no beat is dropped or duplicated.
REQ-021 Sign handling: b is sign-extended to AW bits before multiplication; the product is taken mod 2^AW, e.g. a=3, b=-1 gives 0xFFFD.
REQ-022 q_log is sampled with each beat and travels with it; q_log changes between beats take effect per beat.
REQ-023 q_log of 0 or greater than AW is treated as AW.
REQ-024 Masked result bits above q_log are 0.
REQ-025 Simultaneous in-transfer and out-transfer in the same cycle are both honoured.

Reset
REQ-026 While rstn is low: in_ready=0, out_valid=0, result=0, all stage valids and data cleared.
REQ-027 Beats in flight at reset assertion are discarded.
REQ-028 in_ready=1 from the first clk edge after rstn deasserts.

Configuration
REQ-029 Macro FRODO_MAC_ACC_EN compiles in per-lane accumulation: extra inputs acc_sel (1 bit) and acc_clr (1 bit) are sampled with each beat.
REQ-030 With FRODO_MAC_ACC_EN and acc_sel=1, each lane uses its internal accumulator in place of in_c.
REQ-031 On every out-transfer, the internal accumulator loads the transferred result.
REQ-032 acc_clr=1 forces the addend to 0 for that beat; acc_clr takes priority over acc_sel.
REQ-033 Accumulators reset to 0.
REQ-034 Without the macro, the ports acc_sel and acc_clr and all accumulator logic are absent, and in_c is always the addend.

Structure
REQ-035 Package frodo_mac_pkg holds the default constants for LANES, AW and BW, the q_log width, and a function that builds the q_log mask.
REQ-036 One sub-module, frodo_mac_lane, holds one lane's S1 multiply and S2 add/mask datapath; it is instantiated LANES times.
REQ-037 Handshake and valid control live once in frodo_mac_pipe.

Verification
REQ-038 Setup LANES=4, q_log=16, out_ready=1. Stimulus: lane0 a=0x1234, b=3, c=0x0001. Response: result lane0 = 0x369D exactly 2 cycles after acceptance.
REQ-039 Stimulus: a=0x8000, b=-16, c=0x0005, q_log=15. Response: result = 0x0005. Stimulus: same beat with q_log=16. Response: result = 0x0005.
REQ-040 Stimulus: 10 back-to-back beats, with out_ready low for 3 cycles mid-stream. Response: in_ready drops within 2 beats; all 10 results appear in order, with no loss or duplication.
REQ-041 Stimulus: rstn asserted with 2 beats in flight. Response: out_valid=0 and result=0 during reset; no stale results appear after release.
REQ-042 With FRODO_MAC_ACC_EN: beat1 acc_clr=1 a=2 b=3, then beat2 acc_sel=1 a=4 b=-1. Response: result1 = 6; result2 = 2 (0x0002).
REQ-043 Stimulus: random a, b, c, q_log on all lanes for 10k beats with random out_ready. Response: every result matches the reference model (a*sext(b)+c) mod 2^q_log.
